// File: rtl/iq_pacer_pkg.sv
// Shared defaults, vector payload type and ratio helper for the I/Q rate pacer.
package iq_pacer_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_N_CH    = 2;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_RATIO_W = 8;
  localparam int unsigned DEF_VEC_W   = DEF_N_CH * DEF_DATA_W;

  // One complex vector at the default geometry; channel c at [c*DATA_W +: DATA_W].
  typedef struct packed {
    logic [DEF_VEC_W-1:0] re;
    logic [DEF_VEC_W-1:0] im;
  } iq_vec_t;

  // Ratios 0 and 1 both mean one fast cycle per output sample.
  function automatic int unsigned ratio_eff(input int unsigned r);
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only pointers and level.
module iq_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status and qualified push/pop; requests against full/empty are ignored.
  always_comb begin
    full_c  = (level == LW'(DEPTH));
    empty_c = (level == '0);
    do_push = push && !full_c;
    do_pop  = pop && !empty_c;
    head_c  = mem[rd_ptr];
  end

  // Storage write.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iq_rate_pacer.sv
// Buffers I/Q vectors and releases one per io_ratio cycles with a DSP-rate strobe.
module iq_rate_pacer
  import iq_pacer_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned N_CH    = DEF_N_CH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned RATIO_W = DEF_RATIO_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [RATIO_W-1:0]       io_ratio,
  input  logic                     io_enable,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [N_CH*DATA_W-1:0]   io_in_real,
  input  logic [N_CH*DATA_W-1:0]   io_in_imag,
  output logic                     io_strobe,
  output logic                     io_out_valid,
  output logic [N_CH*DATA_W-1:0]   io_out_real,
  output logic [N_CH*DATA_W-1:0]   io_out_imag,
  output logic [$clog2(DEPTH):0]   io_level,
  output logic                     io_underflow,
  input  logic                     io_clear_underflow
);

  localparam int unsigned VEC_W  = N_CH * DATA_W;
  localparam int unsigned FIFO_W = 2 * VEC_W;

  logic [RATIO_W-1:0] cnt_q;
  logic [RATIO_W-1:0] r_q;
  logic [RATIO_W-1:0] r_use;
  logic [RATIO_W-1:0] r_in;
  logic               first_q;
  logic               wrap;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_W-1:0]  fifo_head;

  // Period length in force; the very first cycle after reset uses the live ratio.
  always_comb begin
    r_in        = RATIO_W'(ratio_eff(32'(io_ratio)));
    r_use       = first_q ? r_in : r_q;
    wrap        = (cnt_q >= r_use - RATIO_W'(1));
    io_strobe   = reset && io_enable && wrap;
    io_in_ready = !fifo_full;
    push        = io_in_valid && io_in_ready;
    pop         = io_strobe && !fifo_empty;
  end

  // Phase counter; ratio re-latched at wrap and continuously while disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      r_q     <= RATIO_W'(1);
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (!io_enable || wrap) begin
        cnt_q <= '0;
        r_q   <= r_in;
      end else begin
        cnt_q <= cnt_q + RATIO_W'(1);
        r_q   <= r_use;
      end
    end
  end

  // Output vector, valid pulse and sticky underflow (set wins over clear).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_out_valid <= 1'b0;
      io_out_real  <= '0;
      io_out_imag  <= '0;
      io_underflow <= 1'b0;
    end else begin
      io_out_valid <= pop;
      if (io_strobe) begin
        io_out_real <= fifo_empty ? '0 : fifo_head[FIFO_W-1 -: VEC_W];
        io_out_imag <= fifo_empty ? '0 : fifo_head[VEC_W-1:0];
      end
      if (io_strobe && fifo_empty) io_underflow <= 1'b1;
      else if (io_clear_underflow) io_underflow <= 1'b0;
    end
  end

  // Vector store: real parts in the upper half, imaginary in the lower.
  iq_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     ({io_in_real, io_in_imag}),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .level   (io_level)
  );

endmodule

// File: tb/tb_iq_rate_pacer.sv
// Self-checking bench for iq_rate_pacer with a vector scoreboard.
module tb_iq_rate_pacer;
  import iq_pacer_pkg::*;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned N_CH    = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned RATIO_W = 8;
  localparam int unsigned VEC_W   = N_CH * DATA_W;
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;

  logic               clock;
  logic               reset;
  logic [RATIO_W-1:0] io_ratio;
  logic               io_enable;
  logic               io_in_valid;
  logic               io_in_ready;
  logic [VEC_W-1:0]   io_in_real;
  logic [VEC_W-1:0]   io_in_imag;
  logic               io_strobe;
  logic               io_out_valid;
  logic [VEC_W-1:0]   io_out_real;
  logic [VEC_W-1:0]   io_out_imag;
  logic [LVL_W-1:0]   io_level;
  logic               io_underflow;
  logic               io_clear_underflow;

  int      n_tests = 0;
  int      n_fail  = 0;
  iq_vec_t sb_q[$];

  iq_rate_pacer #(
    .DATA_W (DATA_W), .N_CH (N_CH), .DEPTH (DEPTH), .RATIO_W (RATIO_W)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_ratio           (io_ratio),
    .io_enable          (io_enable),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_real         (io_in_real),
    .io_in_imag         (io_in_imag),
    .io_strobe          (io_strobe),
    .io_out_valid       (io_out_valid),
    .io_out_real        (io_out_real),
    .io_out_imag        (io_out_imag),
    .io_level           (io_level),
    .io_underflow       (io_underflow),
    .io_clear_underflow (io_clear_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ch0 real = i, imag = -i; ch1 real = 100*i, imag = -100*i.
  function automatic iq_vec_t mk_vec(input int i);
    iq_vec_t v;
    v.re = {16'(i * 100), 16'(i)};
    v.im = {16'(-i * 100), 16'(-i)};
    return v;
  endfunction

  task automatic drive_vec(input iq_vec_t v);
    io_in_real = v.re;
    io_in_imag = v.im;
  endtask

  task automatic test_reset;
    reset = 1'b0; io_ratio = 8'd1; io_enable = 1'b0; io_in_valid = 1'b0;
    io_in_real = '0; io_in_imag = '0; io_clear_underflow = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_tests++;
    if (io_strobe !== 1'b0 || io_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses strobe=%0b valid=%0b exp 0/0", io_strobe, io_out_valid);
    end
    n_tests++;
    if (io_out_real !== '0 || io_out_imag !== '0) begin
      n_fail++; $display("FAIL reset_data re=%h im=%h exp 0", io_out_real, io_out_imag);
    end
    n_tests++;
    if (io_level !== 4'd0 || io_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_state level=%0d uf=%0b exp 0/0", io_level, io_underflow);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_tests++;
    if (io_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %0b exp 1", io_in_ready);
    end
  endtask

  task automatic test_ratio8;
    iq_vec_t v;
    iq_vec_t e;
    int      pulses = 0;
    @(negedge clock);
    io_ratio = 8'd8; io_enable = 1'b0;
    for (int n = 0; n <= 32; n++) begin
      @(negedge clock);
      io_enable   = (n < 32);
      io_in_valid = (n < 4);
      v = mk_vec(n + 1);
      drive_vec(v);
      #1;
      if (io_in_valid && io_in_ready) sb_q.push_back(v);
      n_tests++;
      if (io_strobe !== ((n < 32) && (n % 8 == 7))) begin
        n_fail++; $display("FAIL r8_strobe n=%0d got %0b exp %0b", n, io_strobe, (n < 32) && (n % 8 == 7));
      end
      n_tests++;
      if (io_out_valid !== ((n > 0) && ((n - 1) % 8 == 7))) begin
        n_fail++; $display("FAIL r8_valid n=%0d got %0b", n, io_out_valid);
      end
      if (io_out_valid) begin
        pulses++;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL r8_data n=%0d got re=%h with empty scoreboard", n, io_out_real);
        end else begin
          e = sb_q.pop_front();
          if (io_out_real !== e.re || io_out_imag !== e.im) begin
            n_fail++; $display("FAIL r8_data n=%0d got %h/%h exp %h/%h", n, io_out_real, io_out_imag, e.re, e.im);
          end
        end
      end
    end
    io_in_valid = 1'b0;
    n_tests++;
    if (pulses != 4 || io_underflow !== 1'b0) begin
      n_fail++; $display("FAIL r8_summary pulses=%0d uf=%0b exp 4/0", pulses, io_underflow);
    end
  endtask

  task automatic test_full;
    iq_vec_t v;
    iq_vec_t e;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clock);
      io_enable = 1'b0; io_in_valid = 1'b1;
      v = mk_vec(10 + n);
      drive_vec(v);
      #1;
      if (io_in_valid && io_in_ready) sb_q.push_back(v);
      n_tests++;
      if (io_in_ready !== (n < 8) || io_level !== 4'(n)) begin
        n_fail++; $display("FAIL full_fill n=%0d ready=%0b level=%0d exp %0b/%0d", n, io_in_ready, io_level, n < 8, n);
      end
    end
    @(negedge clock);
    io_in_valid = 1'b0; io_ratio = 8'd1;
    #1;
    n_tests++;
    if (io_level !== 4'd8 || io_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_refuse level=%0d ready=%0b exp 8/0", io_level, io_in_ready);
    end
    for (int n = 0; n <= 8; n++) begin
      @(negedge clock);
      io_enable = (n < 8);
      #1;
      n_tests++;
      if (io_strobe !== (n < 8) || io_out_valid !== (n >= 1) || io_level !== 4'(8 - n)) begin
        n_fail++; $display("FAIL full_drain n=%0d strobe=%0b valid=%0b level=%0d", n, io_strobe, io_out_valid, io_level);
      end
      if (io_out_valid) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL full_data n=%0d got re=%h with empty scoreboard", n, io_out_real);
        end else begin
          e = sb_q.pop_front();
          if (io_out_real !== e.re || io_out_imag !== e.im) begin
            n_fail++; $display("FAIL full_data n=%0d got %h/%h exp %h/%h", n, io_out_real, io_out_imag, e.re, e.im);
          end
        end
      end
    end
    n_tests++;
    if (io_underflow !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL full_end uf=%0b left=%0d exp 0/0", io_underflow, sb_q.size());
    end
  endtask

  task automatic test_empty_strobe;
    iq_vec_t v;
    @(negedge clock);
    io_ratio = 8'd4; io_enable = 1'b0;
    for (int n = 0; n <= 9; n++) begin
      @(negedge clock);
      io_enable          = (n <= 7);
      io_clear_underflow = (n == 7) || (n == 8);
      io_in_valid        = (n == 7);
      v = mk_vec(50);
      drive_vec(v);
      #1;
      if (io_in_valid && io_in_ready) sb_q.push_back(v);
      n_tests++;
      if (io_strobe !== ((n == 3) || (n == 7))) begin
        n_fail++; $display("FAIL empty_strobe n=%0d got %0b", n, io_strobe);
      end
      if (n == 4) begin
        n_tests++;
        if (io_out_valid !== 1'b0 || io_out_real !== '0 || io_out_imag !== '0 || io_underflow !== 1'b1) begin
          n_fail++; $display("FAIL empty_first valid=%0b re=%h im=%h uf=%0b exp 0/0/0/1", io_out_valid, io_out_real, io_out_imag, io_underflow);
        end
      end
      if (n == 8) begin
        n_tests++;
        if (io_underflow !== 1'b1 || io_level !== 4'd1 || io_out_valid !== 1'b0) begin
          n_fail++; $display("FAIL empty_setwins uf=%0b level=%0d valid=%0b exp 1/1/0", io_underflow, io_level, io_out_valid);
        end
      end
      if (n == 9) begin
        n_tests++;
        if (io_underflow !== 1'b0) begin
          n_fail++; $display("FAIL empty_clear uf=%0b exp 0", io_underflow);
        end
      end
    end
    io_clear_underflow = 1'b0; io_in_valid = 1'b0;
  endtask

  task automatic test_ratio_change;
    iq_vec_t e;
    logic    exp_s;
    @(negedge clock);
    io_ratio = 8'd4; io_enable = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      @(negedge clock);
      io_enable = (n < 16);
      if (n == 1)  io_ratio = 8'd2;
      if (n == 11) io_ratio = 8'd0;
      #1;
      exp_s = (n == 3) || (n >= 5 && n <= 11 && (n % 2 == 1)) || (n >= 12 && n < 16);
      n_tests++;
      if (io_strobe !== exp_s) begin
        n_fail++; $display("FAIL rchg_strobe n=%0d got %0b exp %0b", n, io_strobe, exp_s);
      end
      n_tests++;
      if (io_out_valid !== (n == 4)) begin
        n_fail++; $display("FAIL rchg_valid n=%0d got %0b exp %0b", n, io_out_valid, n == 4);
      end
      if (io_out_valid) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL rchg_data n=%0d got re=%h with empty scoreboard", n, io_out_real);
        end else begin
          e = sb_q.pop_front();
          if (io_out_real !== e.re || io_out_imag !== e.im) begin
            n_fail++; $display("FAIL rchg_data n=%0d got %h/%h exp %h/%h", n, io_out_real, io_out_imag, e.re, e.im);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    iq_vec_t v;
    iq_vec_t e;
    @(negedge clock);
    io_ratio = 8'd1; io_enable = 1'b0;
    for (int n = 0; n <= 5; n++) begin
      @(negedge clock);
      io_enable = (n == 5); io_in_valid = 1'b1;
      v = mk_vec(70 + n);
      drive_vec(v);
      #1;
      if (io_in_valid && io_in_ready) sb_q.push_back(v);
    end
    @(negedge clock);
    io_enable = 1'b0; io_in_valid = 1'b0;
    #1;
    e = sb_q.pop_front();
    n_tests++;
    if (io_level !== 4'd5 || io_out_valid !== 1'b1 || io_out_real !== e.re) begin
      n_fail++; $display("FAIL rmid_pre level=%0d valid=%0b re=%h exp 5/1/%h", io_level, io_out_valid, io_out_real, e.re);
    end
    reset = 1'b0;
    sb_q.delete();
    #1;
    n_tests++;
    if (io_level !== 4'd0 || io_out_valid !== 1'b0 || io_out_real !== '0 || io_out_imag !== '0 ||
        io_underflow !== 1'b0 || io_strobe !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async level=%0d valid=%0b re=%h im=%h uf=%0b strobe=%0b exp all 0",
                         io_level, io_out_valid, io_out_real, io_out_imag, io_underflow, io_strobe);
    end
    io_ratio = 8'd3; io_enable = 1'b1;
    repeat (2) @(negedge clock);
    for (int n = 0; n <= 3; n++) begin
      if (n == 0) reset = 1'b1;
      else @(negedge clock);
      #1;
      n_tests++;
      if (io_strobe !== (n == 2)) begin
        n_fail++; $display("FAIL rmid_strobe n=%0d got %0b exp %0b", n, io_strobe, n == 2);
      end
      if (n == 3) begin
        n_tests++;
        if (io_out_valid !== 1'b0 || io_underflow !== 1'b1 || io_out_real !== '0) begin
          n_fail++; $display("FAIL rmid_after valid=%0b uf=%0b re=%h exp 0/1/0", io_out_valid, io_underflow, io_out_real);
        end
      end
    end
    io_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ratio8();
    test_full();
    test_empty_strobe();
    test_ratio_change();
    test_reset_mid();
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
